wt_mem_req_arbiter: RTL and testbench
=====================================

Name: wt_mem_req_arbiter

Overview:
- Shares the single memory-side request channel of the write-through cache subsystem between the instruction cache (source 0) and the data cache (source 1).
- Grants requests round-robin, holding each grant until the memory adapter acknowledges it.
- Keeps a per-source count of outstanding transactions and limits each source to a fixed number in flight.
- Steers return-valid pulses back to the issuing cache and reports busy and protocol-error status.

Parameters:
- PayloadWidth, 128: width of the opaque request payload (address, size, type, tid packed by the cache).
- MaxOutstanding, 4: maximum in-flight transactions per source; must be at least 1.
- CntWidth, $clog2(MaxOutstanding+1): width of each outstanding counter (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ic_req_i  in  1  icache request; held with payload until ic_ack_o
- ic_payload_i  in  PayloadWidth  icache request payload
- ic_ack_o  out  1  icache request accepted
- dc_req_i  in  1  dcache request; held with payload until dc_ack_o
- dc_payload_i  in  PayloadWidth  dcache request payload
- dc_ack_o  out  1  dcache request accepted
- mem_req_o  out  1  request to the memory adapter
- mem_payload_o  out  PayloadWidth  payload of the granted source
- mem_src_o  out  1  granted source (0 = icache, 1 = dcache)
- mem_ack_i  in  1  adapter accepts the current request
- mem_rtrn_vld_i  in  1  return beat valid; return data bypasses this block
- mem_rtrn_src_i  in  1  source tag of the return
- ic_rtrn_vld_o  out  1  return valid routed to the icache
- dc_rtrn_vld_o  out  1  return valid routed to the dcache
- stall_i  in  1  no new grants while high; a grant already made stays until acked
- busy_o  out  1  a grant is active or any transaction is outstanding
- err_o  out  1  sticky flag: return received for a source with zero outstanding

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - state IDLE, both counters 0, priority pointer 0, err_o 0.
  - All outputs 0; mem_payload_o is 0 while not granting.
  - Reset mid-grant drops mem_req_o in the next cycle. In-flight returns are no longer counted.
- State machine has three states: IDLE, GRANT_IC, GRANT_DC.
- IDLE:
  - A source is eligible when its req_i is high, its counter is below MaxOutstanding, and stall_i is low.
  - If both sources are eligible, the priority pointer chooses (0 = icache first).
  - The chosen source moves the FSM to GRANT_IC or GRANT_DC on the next edge. Grant latency is 1 cycle from req_i high.
- GRANT_x:
  - mem_req_o = 1; mem_src_o and mem_payload_o come combinationally from source x.
  - x_ack_o = mem_ack_i, combinational in the same cycle; the other source's ack is 0.
  - On mem_ack_i: increment counter x, set the priority pointer to the other source, return to IDLE. The earliest next grant is 2 cycles later.
  - Without mem_ack_i the grant holds indefinitely; stall_i does not revoke it.
- Return routing:
  - ic_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_src_i.
  - dc_rtrn_vld_o = mem_rtrn_vld_i & mem_rtrn_src_i.
  - Both are combinational and asserted in all states.
  - A return decrements the counter of its source.
- Same-cycle acceptance and return for one source: counter unchanged.
- Return for a source whose counter is 0:
  - counter stays at 0 (no wrap); err_o set and held until reset.
  - the routed valid is still forwarded.
- Counter at MaxOutstanding:
  - that source is ineligible and the other source may be granted.
  - a return in the same cycle does not make it eligible until the next cycle.
- busy_o = (state != IDLE) | (ic_cnt != 0) | (dc_cnt != 0), registered-state based and glitch-free.

Decomposition:
- Add to wt_cache_pkg:
  - typedef mem_src_e {SRC_ICACHE = 0, SRC_DCACHE = 1}
  - FSM state enum arb_state_e
- One sub-module, wt_tx_credit_cnt, instanced per source.
  - Inputs: inc, dec. Outputs: count, full, empty, underflow.
  - Saturating at 0, with the same-cycle inc/dec rule above.

Test Plan:
- Reset, then ic_req_i pulse held, mem_ack_i on the 2nd grant cycle -> mem_req_o rises 1 cycle after req, mem_src_o = 0, ic_ack_o for 1 cycle, ic_cnt = 1, busy_o = 1.
- Both requesters held continuously, mem_ack_i always 1 -> grants alternate IC, DC, IC, DC, with 1 idle cycle between grants; payloads match their sources.
- MaxOutstanding = 4, dcache issues 4 with no returns -> 5th dc_req_i is not granted and ic still is; one dcache return -> dcache granted 2 cycles later.
- Acceptance and return for the icache in the same cycle with ic_cnt = 2 -> ic_cnt stays 2, ic_rtrn_vld_o = 1, dc_rtrn_vld_o = 0.
- mem_rtrn_vld_i with src = 1 while dc_cnt = 0 -> dc_rtrn_vld_o = 1, err_o = 1 and stays 1, dc_cnt stays 0.
- stall_i high during GRANT_DC with mem_ack_i 3 cycles later -> grant held and completed, no new grant while stall_i is high; rst_i mid-grant -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache subsystem memory-side logic.
package wt_cache_pkg;

  // Source tag carried alongside every memory request and return.
  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } mem_src_e;

  // Memory request arbiter state: idle, or holding a grant for one source.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wt_tx_credit_cnt.sv
// Outstanding-transaction counter for one cache source.
// Counts accepted requests up and returns down, never wrapping below zero.
module wt_tx_credit_cnt #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc,
  input  logic                dec,
  output logic [CntWidth-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                underflow
);

  logic [CntWidth-1:0] count_q;

  // Simultaneous inc and dec cancel; a lone dec at zero saturates and flags underflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc && !dec) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc && !empty) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntWidth'(MaxOutstanding));
  assign underflow = dec && !inc && empty;

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the memory request channel between the
// icache and dcache, with per-source in-flight limits and return steering.
module wt_mem_req_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned PayloadWidth   = 128,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ic_req_i,
  input  logic [PayloadWidth-1:0] ic_payload_i,
  output logic                    ic_ack_o,
  input  logic                    dc_req_i,
  input  logic [PayloadWidth-1:0] dc_payload_i,
  output logic                    dc_ack_o,
  output logic                    mem_req_o,
  output logic [PayloadWidth-1:0] mem_payload_o,
  output logic                    mem_src_o,
  input  logic                    mem_ack_i,
  input  logic                    mem_rtrn_vld_i,
  input  logic                    mem_rtrn_src_i,
  output logic                    ic_rtrn_vld_o,
  output logic                    dc_rtrn_vld_o,
  input  logic                    stall_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  arb_state_e          state_q, state_d;
  mem_src_e            prio_q, prio_d;
  logic                err_q;
  logic                ic_inc, dc_inc;
  logic                ic_full, dc_full, ic_empty, dc_empty;
  logic                ic_underflow, dc_underflow;
  logic [CntWidth-1:0] ic_cnt, dc_cnt;
  logic                ic_elig, dc_elig;

  assign ic_rtrn_vld_o = mem_rtrn_vld_i && !mem_rtrn_src_i;
  assign dc_rtrn_vld_o = mem_rtrn_vld_i && mem_rtrn_src_i;

  assign ic_elig = ic_req_i && !ic_full && !stall_i;
  assign dc_elig = dc_req_i && !dc_full && !stall_i;

  wt_tx_credit_cnt #(
    .MaxOutstanding(MaxOutstanding),
    .CntWidth      (CntWidth)
  ) u_ic_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (ic_inc),
    .dec      (ic_rtrn_vld_o),
    .count    (ic_cnt),
    .full     (ic_full),
    .empty    (ic_empty),
    .underflow(ic_underflow)
  );

  wt_tx_credit_cnt #(
    .MaxOutstanding(MaxOutstanding),
    .CntWidth      (CntWidth)
  ) u_dc_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (dc_inc),
    .dec      (dc_rtrn_vld_o),
    .count    (dc_cnt),
    .full     (dc_full),
    .empty    (dc_empty),
    .underflow(dc_underflow)
  );

  // State, priority pointer and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= SRC_ICACHE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (ic_underflow || dc_underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  // Grant selection and the request channel mux driven by the active grant.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    mem_req_o     = 1'b0;
    mem_src_o     = 1'b0;
    mem_payload_o = '0;
    ic_ack_o      = 1'b0;
    dc_ack_o      = 1'b0;
    ic_inc        = 1'b0;
    dc_inc        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ic_elig && (!dc_elig || prio_q == SRC_ICACHE)) begin
          state_d = GRANT_IC;
        end else if (dc_elig) begin
          state_d = GRANT_DC;
        end
      end
      GRANT_IC: begin
        mem_req_o     = 1'b1;
        mem_src_o     = SRC_ICACHE;
        mem_payload_o = ic_payload_i;
        ic_ack_o      = mem_ack_i;
        if (mem_ack_i) begin
          ic_inc  = 1'b1;
          prio_d  = SRC_DCACHE;
          state_d = IDLE;
        end
      end
      GRANT_DC: begin
        mem_req_o     = 1'b1;
        mem_src_o     = SRC_DCACHE;
        mem_payload_o = dc_payload_i;
        dc_ack_o      = mem_ack_i;
        if (mem_ack_i) begin
          dc_inc  = 1'b1;
          prio_d  = SRC_ICACHE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE) || !ic_empty || !dc_empty;
  assign err_o  = err_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: per-scenario tasks plus a
// scoreboard of expected (source, payload) pairs consumed on each acceptance.
module tb_wt_mem_req_arbiter;

  localparam int unsigned PW = 128;

  typedef struct {
    logic          src;
    logic [PW-1:0] payload;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ic_req_i, dc_req_i;
  logic [PW-1:0] ic_payload_i, dc_payload_i;
  logic          ic_ack_o, dc_ack_o;
  logic          mem_req_o;
  logic [PW-1:0] mem_payload_o;
  logic          mem_src_o;
  logic          mem_ack_i;
  logic          mem_rtrn_vld_i, mem_rtrn_src_i;
  logic          ic_rtrn_vld_o, dc_rtrn_vld_o;
  logic          stall_i;
  logic          busy_o, err_o;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  logic [PW-1:0] ic_pat = {4{32'hA5A5_0001}};
  logic [PW-1:0] dc_pat = {4{32'h5A5A_0002}};

  wt_mem_req_arbiter #(.PayloadWidth(PW), .MaxOutstanding(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ic_req_i      (ic_req_i),
    .ic_payload_i  (ic_payload_i),
    .ic_ack_o      (ic_ack_o),
    .dc_req_i      (dc_req_i),
    .dc_payload_i  (dc_payload_i),
    .dc_ack_o      (dc_ack_o),
    .mem_req_o     (mem_req_o),
    .mem_payload_o (mem_payload_o),
    .mem_src_o     (mem_src_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rtrn_vld_i(mem_rtrn_vld_i),
    .mem_rtrn_src_i(mem_rtrn_src_i),
    .ic_rtrn_vld_o (ic_rtrn_vld_o),
    .dc_rtrn_vld_o (dc_rtrn_vld_o),
    .stall_i       (stall_i),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  // Checks any acceptance in the current cycle against the scoreboard, then advances one clock.
  task automatic step();
    exp_t e;
    #1;
    if (mem_req_o === 1'b1 && mem_ack_i === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected_accept: got src=%0b payload=%0h, required no acceptance", mem_src_o, mem_payload_o);
      end else begin
        e = sb.pop_front();
        if (mem_src_o !== e.src || mem_payload_o !== e.payload) begin
          miscompares++;
          $display("[TB] FAIL sb_accept: got src=%0b payload=%0h, required src=%0b payload=%0h", mem_src_o, mem_payload_o, e.src, e.payload);
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ic_req_i = 1'b0; dc_req_i = 1'b0; mem_ack_i = 1'b0;
    mem_rtrn_vld_i = 1'b0; mem_rtrn_src_i = 1'b0; stall_i = 1'b0;
    ic_payload_i = ic_pat; dc_payload_i = dc_pat;
    step();
    step();
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o, ic_ack_o, dc_ack_o, busy_o, err_o, ic_rtrn_vld_o, dc_rtrn_vld_o} !== 8'b0 || mem_payload_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got req=%0b src=%0b acks=%0b%0b busy=%0b err=%0b payload=%0h, required all 0",
               mem_req_o, mem_src_o, ic_ack_o, dc_ack_o, busy_o, err_o, mem_payload_o);
    end
    rst_i = 1'b0;
    sb.delete();
    step();
  endtask

  task automatic test_single_ic();
    ic_req_i = 1'b1;
    sb.push_back('{src: 1'b0, payload: ic_pat});
    #1;
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_latency: got mem_req=%0b, required 0", mem_req_o);
    end
    step();
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o, ic_ack_o, dc_ack_o} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got req/src/ica/dca=%4b, required 1000", {mem_req_o, mem_src_o, ic_ack_o, dc_ack_o});
    end
    step();
    mem_ack_i = 1'b1;
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o, ic_ack_o, dc_ack_o} !== 4'b1010 || mem_payload_o !== ic_pat) begin
      miscompares++;
      $display("[TB] FAIL single_ack: got req/src/ica/dca=%4b payload=%0h, required 1010 payload=%0h",
               {mem_req_o, mem_src_o, ic_ack_o, dc_ack_o}, mem_payload_o, ic_pat);
    end
    step();
    ic_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || ic_ack_o !== 1'b0 || dut.ic_cnt !== 3'd1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_count: got req=%0b ica=%0b ic_cnt=%0d busy=%0b, required 0 0 1 1", mem_req_o, ic_ack_o, dut.ic_cnt, busy_o);
    end
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b0;
    step();
    mem_rtrn_vld_i = 1'b0;
    #1;
    vectors++;
    if (dut.ic_cnt !== 3'd0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_return: got ic_cnt=%0d busy=%0b err=%0b, required 0 0 0", dut.ic_cnt, busy_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_src;
    test_reset();
    ic_req_i = 1'b1; dc_req_i = 1'b1; mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{src: i[0], payload: i[0] ? dc_pat : ic_pat});
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_src = ((i / 2) % 2) == 1;
      vectors++;
      if (i % 2 == 0) begin
        if (mem_req_o !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_idle_%0d: got mem_req=%0b, required 0", i, mem_req_o);
        end
      end else if (mem_req_o !== 1'b1 || mem_src_o !== exp_src || mem_payload_o !== (exp_src ? dc_pat : ic_pat)) begin
        miscompares++;
        $display("[TB] FAIL b2b_grant_%0d: got req=%0b src=%0b payload=%0h, required 1 %0b", i, mem_req_o, mem_src_o, mem_payload_o, exp_src);
      end
      step();
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    vectors++;
    if (dut.ic_cnt !== 3'd2 || dut.dc_cnt !== 3'd2 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_counts: got ic=%0d dc=%0d pending=%0d, required 2 2 0", dut.ic_cnt, dut.dc_cnt, sb.size());
    end
  endtask

  task automatic test_max_outstanding();
    test_reset();
    dc_req_i = 1'b1; mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{src: 1'b1, payload: dc_pat});
    for (int i = 0; i < 8; i++) step();
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || dut.dc_cnt !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL full_count: got req=%0b dc_cnt=%0d, required 0 4", mem_req_o, dut.dc_cnt);
    end
    step();
    ic_req_i = 1'b1;
    sb.push_back('{src: 1'b0, payload: ic_pat});
    #1;
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_no_dc_grant: got mem_req=%0b, required 0", mem_req_o);
    end
    step();
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o, ic_ack_o} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL full_ic_grant: got req/src/ica=%3b, required 101", {mem_req_o, mem_src_o, ic_ack_o});
    end
    step();
    ic_req_i = 1'b0;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b1;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || dc_rtrn_vld_o !== 1'b1 || ic_rtrn_vld_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_return: got req=%0b dcr=%0b icr=%0b, required 0 1 0", mem_req_o, dc_rtrn_vld_o, ic_rtrn_vld_o);
    end
    step();
    mem_rtrn_vld_i = 1'b0;
    sb.push_back('{src: 1'b1, payload: dc_pat});
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || dut.dc_cnt !== 3'd3) begin
      miscompares++;
      $display("[TB] FAIL full_release_wait: got req=%0b dc_cnt=%0d, required 0 3", mem_req_o, dut.dc_cnt);
    end
    step();
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o, dc_ack_o} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL full_dc_regrant: got req/src/dca=%3b, required 111", {mem_req_o, mem_src_o, dc_ack_o});
    end
    step();
    dc_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    vectors++;
    if (dut.dc_cnt !== 3'd4 || dut.ic_cnt !== 3'd1 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL full_final: got dc=%0d ic=%0d pending=%0d, required 4 1 0", dut.dc_cnt, dut.ic_cnt, sb.size());
    end
  endtask

  task automatic test_same_cycle();
    test_reset();
    ic_req_i = 1'b1; mem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{src: 1'b0, payload: ic_pat});
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b0;
        #1;
        vectors++;
        if (ic_ack_o !== 1'b1 || ic_rtrn_vld_o !== 1'b1 || dc_rtrn_vld_o !== 1'b0 || dut.ic_cnt !== 3'd2) begin
          miscompares++;
          $display("[TB] FAIL same_cycle_io: got ica=%0b icr=%0b dcr=%0b ic_cnt=%0d, required 1 1 0 2",
                   ic_ack_o, ic_rtrn_vld_o, dc_rtrn_vld_o, dut.ic_cnt);
        end
      end
      step();
    end
    ic_req_i = 1'b0; mem_ack_i = 1'b0; mem_rtrn_vld_i = 1'b0;
    #1;
    vectors++;
    if (dut.ic_cnt !== 3'd2 || err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_count: got ic_cnt=%0d err=%0b, required 2 0", dut.ic_cnt, err_o);
    end
  endtask

  task automatic test_underflow();
    test_reset();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b1;
    #1;
    vectors++;
    if (dc_rtrn_vld_o !== 1'b1 || ic_rtrn_vld_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL underflow_route: got dcr=%0b icr=%0b, required 1 0", dc_rtrn_vld_o, ic_rtrn_vld_o);
    end
    step();
    mem_rtrn_vld_i = 1'b0;
    #1;
    vectors++;
    if (err_o !== 1'b1 || dut.dc_cnt !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL underflow_err: got err=%0b dc_cnt=%0d, required 1 0", err_o, dut.dc_cnt);
    end
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL underflow_sticky: got err=%0b, required 1", err_o);
    end
  endtask

  task automatic test_stall_and_reset();
    test_reset();
    dc_req_i = 1'b1;
    sb.push_back('{src: 1'b1, payload: dc_pat});
    step();
    stall_i = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      #1;
      vectors++;
      if ({mem_req_o, mem_src_o, dc_ack_o} !== 3'b110) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d: got req/src/dca=%3b, required 110", j, {mem_req_o, mem_src_o, dc_ack_o});
      end
      step();
    end
    mem_ack_i = 1'b1;
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o, dc_ack_o} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL stall_complete: got req/src/dca=%3b, required 111", {mem_req_o, mem_src_o, dc_ack_o});
    end
    step();
    mem_ack_i = 1'b0; ic_req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_no_grant_%0d: got req=%0b busy=%0b, required 0 1", k, mem_req_o, busy_o);
      end
      step();
    end
    stall_i = 1'b0;
    sb.push_back('{src: 1'b0, payload: ic_pat});
    step();
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o} !== 2'b10 || mem_payload_o !== ic_pat) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got req=%0b src=%0b payload=%0h, required 1 0 %0h", mem_req_o, mem_src_o, mem_payload_o, ic_pat);
    end
    rst_i = 1'b1;
    step();
    #1;
    vectors++;
    if ({mem_req_o, mem_src_o, ic_ack_o, dc_ack_o, busy_o, err_o, ic_rtrn_vld_o, dc_rtrn_vld_o} !== 8'b0 ||
        mem_payload_o !== '0 || dut.dc_cnt !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_grant: got req=%0b src=%0b busy=%0b payload=%0h dc_cnt=%0d, required all 0",
               mem_req_o, mem_src_o, busy_o, mem_payload_o, dut.dc_cnt);
    end
    sb.delete();
    rst_i = 1'b0; ic_req_i = 1'b0; dc_req_i = 1'b0;
    step();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_single_ic();
    test_back_to_back();
    test_max_outstanding();
    test_same_cycle();
    test_underflow();
    test_stall_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
